// File: rtl/i2c_slave_rx_if.sv
// Bus bundle for the I2C slave receiver: pad-level scl/sda plus the
// downstream byte handshake and status flags.
interface i2c_slave_rx_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_first;
    logic       busy;
    logic       stop_det;
    logic       ovf;

    modport slave (
        input  scl_i, sda_i, rx_ready,
        output sda_o, rx_data, rx_valid, rx_first, busy, stop_det, ovf
    );

    modport master (
        output scl_i, sda_i, rx_ready,
        input  sda_o, rx_data, rx_valid, rx_first, busy, stop_det, ovf
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// I2C slave receiver: synchronises and glitch-filters scl/sda, detects
// START/STOP/repeated START, matches a 7-bit address and receives
// master-write bytes into a valid/ready output register, ACKing each byte
// only while the downstream register has room and the byte budget allows.
module i2c_slave_rx #(
    parameter logic [6:0] DEV_ADDR    = 7'h3C,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3,
    parameter int         MAX_BYTES   = 16
) (
    input  logic            clk,
    input  logic            rst,
    i2c_slave_rx_if.slave   bus
);
    localparam int                CNT_W   = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
    logic [FILTER_LEN-1:0]  scl_hist_r, sda_hist_r;
    logic                   scl_f_r, sda_f_r, scl_d_r, sda_d_r;
    logic                   scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t                 state_r, state_s;
    logic [2:0]             bit_cnt_r, bit_cnt_s;
    logic [6:0]             shift_r, shift_s;
    logic [7:0]             byte_s;
    logic                   ack_r, ack_s;
    logic                   ack_drv_r, ack_drv_s;
    logic [CNT_W-1:0]       byte_cnt_r, byte_cnt_s;
    logic                   sda_o_r, sda_o_s;
    logic                   busy_r, busy_s;
    logic                   load_s, ovf_set_s, room_s;
    logic [7:0]             rx_data_r;
    logic                   rx_valid_r, rx_first_r, stop_det_r, ovf_r;

    // Synchroniser, run-length filter and previous-level registers per line
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_hist_r <= {FILTER_LEN{1'b1}};
            sda_hist_r <= {FILTER_LEN{1'b1}};
            scl_f_r    <= 1'b1;
            sda_f_r    <= 1'b1;
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], bus.sda_i};
            scl_hist_r <= FILTER_LEN'({scl_hist_r, scl_sync_r[SYNC_STAGES-1]});
            sda_hist_r <= FILTER_LEN'({sda_hist_r, sda_sync_r[SYNC_STAGES-1]});
            if (&scl_hist_r)       scl_f_r <= 1'b1;
            else if (~|scl_hist_r) scl_f_r <= 1'b0;
            else                   scl_f_r <= scl_f_r;
            if (&sda_hist_r)       sda_f_r <= 1'b1;
            else if (~|sda_hist_r) sda_f_r <= 1'b0;
            else                   sda_f_r <= sda_f_r;
            scl_d_r <= scl_f_r;
            sda_d_r <= sda_f_r;
        end
    end

    assign scl_rise_s = scl_f_r & ~scl_d_r;
    assign scl_fall_s = ~scl_f_r & scl_d_r;
    assign start_s    = ~sda_f_r & sda_d_r & scl_f_r;
    assign stop_s     = sda_f_r & ~sda_d_r & scl_f_r;
    assign byte_s     = {shift_r, sda_f_r};
    assign room_s     = ~rx_valid_r | bus.rx_ready;

    // Next-state and datapath decisions; bus conditions override bit sampling
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        ack_s      = ack_r;
        ack_drv_s  = ack_drv_r;
        byte_cnt_s = byte_cnt_r;
        sda_o_s    = sda_o_r;
        busy_s     = busy_r;
        load_s     = 1'b0;
        ovf_set_s  = 1'b0;
        if (stop_s) begin
            state_s   = IDLE;
            sda_o_s   = 1'b1;
            busy_s    = 1'b0;
            ack_drv_s = 1'b0;
            bit_cnt_s = 3'd0;
        end else if (start_s) begin
            state_s    = ADDR;
            bit_cnt_s  = 3'd0;
            byte_cnt_s = {CNT_W{1'b0}};
            sda_o_s    = 1'b1;
            ack_drv_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    sda_o_s = 1'b1;
                end
                ADDR: begin
                    if (scl_rise_s) begin
                        shift_s   = byte_s[6:0];
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_s = ADDR_ACK;
                            ack_s   = (byte_s[7:1] == DEV_ADDR) && !byte_s[0];
                            busy_s  = (byte_s[7:1] == DEV_ADDR) && !byte_s[0];
                        end else begin
                            state_s = ADDR;
                        end
                    end else begin
                        state_s = ADDR;
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall_s) begin
                        if (!ack_drv_r) begin
                            sda_o_s   = ~ack_r;
                            ack_drv_s = 1'b1;
                        end else begin
                            sda_o_s   = 1'b1;
                            ack_drv_s = 1'b0;
                            state_s   = ack_r ? DATA : IGNORE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                DATA: begin
                    if (scl_rise_s) begin
                        shift_s   = byte_s[6:0];
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_s = DATA_ACK;
                            if ((byte_cnt_r < MAX_CNT) && room_s) begin
                                load_s     = 1'b1;
                                ack_s      = 1'b1;
                                byte_cnt_s = byte_cnt_r + CNT_W'(1);
                            end else begin
                                ack_s     = 1'b0;
                                ovf_set_s = (byte_cnt_r < MAX_CNT);
                            end
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        state_s = DATA;
                    end
                end
                IGNORE: begin
                    sda_o_s = 1'b1;
                end
                default: begin
                    state_s = IDLE;
                    sda_o_s = 1'b1;
                end
            endcase
        end
    end

    // Protocol state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 7'd0;
            ack_r      <= 1'b0;
            ack_drv_r  <= 1'b0;
            byte_cnt_r <= {CNT_W{1'b0}};
            sda_o_r    <= 1'b1;
            busy_r     <= 1'b0;
            stop_det_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            ack_r      <= ack_s;
            ack_drv_r  <= ack_drv_s;
            byte_cnt_r <= byte_cnt_s;
            sda_o_r    <= sda_o_s;
            busy_r     <= busy_s;
            stop_det_r <= stop_s;
            ovf_r      <= ovf_r | ovf_set_s;
        end
    end

    // Output byte register; a new load wins over consumption in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
            rx_first_r <= 1'b0;
        end else if (load_s) begin
            rx_data_r  <= byte_s;
            rx_valid_r <= 1'b1;
            rx_first_r <= (byte_cnt_r == {CNT_W{1'b0}});
        end else if (rx_valid_r && bus.rx_ready) begin
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= rx_valid_r;
        end
    end

    assign bus.sda_o    = sda_o_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.rx_first = rx_first_r;
    assign bus.busy     = busy_r;
    assign bus.stop_det = stop_det_r;
    assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: bit-banged I2C master, two slaves
// (MAX_BYTES=16 and MAX_BYTES=2) on private open-drain lines sharing the
// master drive, and a negedge monitor collecting delivered bytes.
module tb_i2c_slave_rx;
    localparam int Q = 10;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic scl_m    = 1'b1;
    logic sda_m    = 1'b1;
    logic rx_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] q1[$];
    logic [8:0] q2[$];
    int   stop_cnt1 = 0;
    logic vseen1    = 1'b0;
    logic low_seen1 = 1'b0;

    logic a1, a2;

    always #5 clk = ~clk;

    i2c_slave_rx_if bus1();
    i2c_slave_rx_if bus2();

    assign bus1.scl_i    = scl_m;
    assign bus1.sda_i    = sda_m & bus1.sda_o;
    assign bus1.rx_ready = rx_ready;
    assign bus2.scl_i    = scl_m;
    assign bus2.sda_i    = sda_m & bus2.sda_o;
    assign bus2.rx_ready = rx_ready;

    i2c_slave_rx #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2), .FILTER_LEN(3), .MAX_BYTES(16))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    i2c_slave_rx #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2), .FILTER_LEN(3), .MAX_BYTES(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Monitor: record consumed bytes, STOP pulses, any valid and any SDA pull
    always @(negedge clk) begin
        if (bus1.rx_valid && rx_ready) q1.push_back({bus1.rx_first, bus1.rx_data});
        if (bus2.rx_valid && rx_ready) q2.push_back({bus2.rx_first, bus2.rx_data});
        if (bus1.stop_det) stop_cnt1 <= stop_cnt1 + 1;
        if (bus1.rx_valid) vseen1 <= 1'b1;
        if (!bus1.sda_o)   low_seen1 <= 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        scl_m = 1'b1;
        sda_m = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(10);
        @(posedge clk);
        q1.delete();
        q2.delete();
        stop_cnt1 = 0;
        vseen1    = 1'b0;
        low_seen1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic glitch();
        scl_m = 1'b1; @(negedge clk);
        scl_m = 1'b0; wait_clk(2);
    endtask

    // One byte plus the ninth clock; returns each slave's sda_o mid-ninth-clock.
    // With rst_mid set, reset is pulsed in the middle of the ninth clock.
    task automatic send_byte(input logic [7:0] b, input logic rst_mid,
                             output logic ack1, output logic ack2);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        ack1 = bus1.sda_o;
        ack2 = bus2.sda_o;
        if (rst_mid) begin
            check_val("rst_pre_sda_o", bus1.sda_o, 1'b0);
            check_val("rst_pre_valid", bus1.rx_valid, 1'b1);
            rst = 1'b1; @(negedge clk);
            rst = 1'b0;
            check_val("rst_sda_o", bus1.sda_o, 1'b1);
            check_val("rst_valid", bus1.rx_valid, 1'b0);
            check_val("rst_data", bus1.rx_data, 8'h00);
            check_val("rst_first", bus1.rx_first, 1'b0);
            check_val("rst_busy", bus1.busy, 1'b0);
            check_val("rst_stop_det", bus1.stop_det, 1'b0);
            check_val("rst_ovf", bus1.ovf, 1'b0);
        end
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    initial begin
        do_reset();
        check_val("reset_sda_o", bus1.sda_o, 1'b1);
        check_val("reset_valid", bus1.rx_valid, 1'b0);
        check_val("reset_data", bus1.rx_data, 8'h00);
        check_val("reset_busy", bus1.busy, 1'b0);
        check_val("reset_ovf", bus1.ovf, 1'b0);
        check_val("reset_stop_det", bus1.stop_det, 1'b0);

        // Write 0xA5, 0x5A to our address with the consumer always ready
        rx_ready = 1'b1;
        i2c_start();
        send_byte(8'h78, 1'b0, a1, a2); check_val("t1_addr_ack", a1, 1'b0);
        check_val("t1_busy", bus1.busy, 1'b1);
        send_byte(8'hA5, 1'b0, a1, a2); check_val("t1_d0_ack", a1, 1'b0);
        send_byte(8'h5A, 1'b0, a1, a2); check_val("t1_d1_ack", a1, 1'b0);
        i2c_stop();
        wait_clk(10);
        check_val("t1_count", q1.size(), 2);
        check_val("t1_byte0", (q1.size() > 0) ? q1[0] : 9'h1FF, 9'h1A5);
        check_val("t1_byte1", (q1.size() > 1) ? q1[1] : 9'h1FF, 9'h05A);
        check_val("t1_stop_cnt", stop_cnt1, 1);
        check_val("t1_busy_end", bus1.busy, 1'b0);

        // Wrong address: slave stays silent
        do_reset();
        i2c_start();
        send_byte(8'h7A, 1'b0, a1, a2); check_val("t2_addr_nack", a1, 1'b1);
        send_byte(8'h11, 1'b0, a1, a2); check_val("t2_data_nack", a1, 1'b1);
        check_val("t2_busy", bus1.busy, 1'b0);
        i2c_stop();
        wait_clk(10);
        check_val("t2_sda_low_seen", low_seen1, 1'b0);
        check_val("t2_valid_seen", vseen1, 1'b0);
        check_val("t2_stop_cnt", stop_cnt1, 1);

        // Read request to our address is NACKed and ignored
        do_reset();
        i2c_start();
        send_byte(8'h79, 1'b0, a1, a2); check_val("t3_addr_nack", a1, 1'b1);
        send_byte(8'h55, 1'b0, a1, a2); check_val("t3_data_nack", a1, 1'b1);
        check_val("t3_busy", bus1.busy, 1'b0);
        i2c_stop();
        wait_clk(10);
        check_val("t3_valid_seen", vseen1, 1'b0);

        // Stalled consumer: second byte NACKed, overflow flagged, first byte held
        do_reset();
        rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h78, 1'b0, a1, a2); check_val("t4_addr_ack", a1, 1'b0);
        send_byte(8'h01, 1'b0, a1, a2); check_val("t4_d0_ack", a1, 1'b0);
        send_byte(8'h02, 1'b0, a1, a2); check_val("t4_d1_nack", a1, 1'b1);
        check_val("t4_ovf", bus1.ovf, 1'b1);
        check_val("t4_held_data", bus1.rx_data, 8'h01);
        check_val("t4_held_first", bus1.rx_first, 1'b1);
        i2c_stop();
        wait_clk(10);
        check_val("t4_valid_after_stop", bus1.rx_valid, 1'b1);
        check_val("t4_data_after_stop", bus1.rx_data, 8'h01);
        rx_ready = 1'b1;
        wait_clk(4);
        check_val("t4_count", q1.size(), 1);
        check_val("t4_byte0", (q1.size() > 0) ? q1[0] : 9'h1FF, 9'h101);
        check_val("t4_valid_drop", bus1.rx_valid, 1'b0);

        // Byte budget on the MAX_BYTES=2 slave
        do_reset();
        i2c_start();
        send_byte(8'h78, 1'b0, a1, a2); check_val("t5_addr_ack", a2, 1'b0);
        send_byte(8'h10, 1'b0, a1, a2); check_val("t5_d0_ack", a2, 1'b0);
        send_byte(8'h20, 1'b0, a1, a2); check_val("t5_d1_ack", a2, 1'b0);
        send_byte(8'h30, 1'b0, a1, a2); check_val("t5_d2_nack", a2, 1'b1);
        check_val("t5_big_d2_ack", a1, 1'b0);
        i2c_stop();
        wait_clk(10);
        check_val("t5_ovf", bus2.ovf, 1'b0);
        check_val("t5_count", q2.size(), 2);
        check_val("t5_byte1", (q2.size() > 1) ? q2[1] : 9'h1FF, 9'h020);
        check_val("t5_big_count", q1.size(), 3);

        // SCL glitches, partial byte cut by a repeated START
        do_reset();
        i2c_start();
        send_byte(8'h78, 1'b0, a1, a2); check_val("t6_addr_ack", a1, 1'b0);
        glitch();
        glitch();
        send_bit(1'b1); glitch();
        send_bit(1'b0); glitch();
        send_bit(1'b1); glitch();
        send_bit(1'b1); glitch();
        check_val("t6_no_partial", vseen1, 1'b0);
        i2c_start();
        send_byte(8'h78, 1'b0, a1, a2); check_val("t6_readdr_ack", a1, 1'b0);
        send_byte(8'hC3, 1'b0, a1, a2); check_val("t6_data_ack", a1, 1'b0);
        i2c_stop();
        wait_clk(10);
        check_val("t6_count", q1.size(), 1);
        check_val("t6_byte0", (q1.size() > 0) ? q1[0] : 9'h1FF, 9'h1C3);

        // Reset during the ACK of a held byte
        do_reset();
        rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h78, 1'b0, a1, a2);
        send_byte(8'h55, 1'b1, a1, a2);
        i2c_stop();
        rx_ready = 1'b1;
        wait_clk(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
Parametrised I2C slave receiver, the next generation of the single-byte bus reader. Adds input synchronisation and glitch filtering, START/STOP/repeated-START detection and 7-bit address matching. It receives multi-byte master-write transfers, decides ACK/NACK per byte from downstream buffer state, and presents bytes through a valid/ready handshake. It sits between the pad-level scl/sda signals and register-file or FIFO logic.

Parameters:
DEV_ADDR, 7'h3C, 7-bit slave address that this block acknowledges.
SYNC_STAGES, 2, synchroniser flops on scl_i and sda_i (min 2).
FILTER_LEN, 3, consecutive equal synchronised samples needed to change a filtered line level (min 1).
MAX_BYTES, 16, data bytes ACKed per transaction after the address (min 1); later bytes are NACKed.

Ports:
clk  in  1  system clock; scl/sda are oversampled (clk ≥ 20× SCL).
rst  in  1  synchronous active-high reset.
scl_i  in  1  raw SCL pad input.
sda_i  in  1  raw SDA pad input.
sda_o  out  1  SDA open-drain control; 0 = pull low, 1 = release.
rx_data  out  8  received data byte, MSB first on the wire.
rx_valid  out  1  rx_data holds an unconsumed byte.
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready at a clk edge.
rx_first  out  1  qualifies rx_data; 1 = first data byte after the address.
busy  out  1  1 from a START that addresses this slave until STOP or a non-matching repeated START.
stop_det  out  1  one-cycle pulse on any STOP condition.
ovf  out  1  sticky; set when a byte is NACKed because the buffer is full; cleared by rst.

Behaviour:
- Reset values (clk edge with rst=1): sda_o=1, rx_valid=0, rx_data=0, rx_first=0, busy=0, stop_det=0, ovf=0, state=IDLE, filtered scl=sda=1, byte counters=0.
- Input conditioning: SYNC_STAGES flops per line, then a FILTER_LEN-deep filter. The filtered level changes only after FILTER_LEN equal consecutive samples. Edges (scl_rise, scl_fall, sda_rise, sda_fall) are single-cycle compares of the filtered level against its previous value.
- START = sda_fall while filtered scl=1. STOP = sda_rise while filtered scl=1. Data bits are sampled on scl_rise, MSB first, with a 3-bit bit counter.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: START -> ADDR.
- ADDR: after the 8th scl_rise, compare bits[7:1] with DEV_ADDR.
  - Match and R/W=0 -> ADDR_ACK with ack=1; set busy.
  - Otherwise -> ADDR_ACK with ack=0, then IGNORE.
- ADDR_ACK / DATA_ACK:
  - On the scl_fall that ends the 8th bit, sda_o=~ack.
  - Keep that value through the 9th clock; release sda_o=1 on the following scl_fall.
  - Then go to DATA if ack=1, otherwise IGNORE.
- DATA: at the 8th scl_rise of a byte:
  - If the byte count < MAX_BYTES and (rx_valid=0, or rx_valid & rx_ready in the same cycle): load rx_data, set rx_valid=1 on the next clk, set rx_first if this is byte 0, increment the byte count, ack=1.
  - Else the byte is discarded and ack=0. If the cause was a full buffer (not MAX_BYTES), set ovf.
  - Go to DATA_ACK.
  - After a NACKed data byte -> IGNORE.
- IGNORE: sda_o held 1; wait for START or STOP.
- Handshake: rx_valid stays high until a clk with rx_ready=1, then drops on the next edge. rx_data is stable while rx_valid=1.
- Latency: rx_valid rises 1 clk after the filtered scl_rise that samples bit 0 of the byte.
- STOP in any state: state=IDLE, sda_o=1, busy=0, stop_det pulses one cycle. A pending rx_valid byte is kept for the consumer.
- Repeated START in any non-IDLE state:
  - state=ADDR; bit counter and byte counter cleared; sda_o=1.
  - busy stays 1 until the new address is judged.
  - A partial byte is discarded; no rx_valid for it.
- START/STOP takes priority over a data-bit sample in the same cycle.
- Byte counter saturates at MAX_BYTES.
- rst mid-transfer returns every output to its reset value immediately on the edge; a pending byte is lost.

Test Plan:
- Write 0x78, 0xA5, 0x5A with rx_ready=1, then STOP.
  - Required: ACK on all 3 ninth clocks (sda_o=0); rx_data 0xA5 (rx_first=1) then 0x5A (rx_first=0); stop_det pulses once; busy falls.
- Address 0x7A (wrong address), then 0x11.
  - Required: sda_o stays 1 throughout; no rx_valid; busy=0; stop_det pulses on STOP.
- Address 0x79 (R/W=1).
  - Required: NACK on the 9th clock; IGNORE until STOP.
- rx_ready=0, write 0x78, 0x01, 0x02.
  - Required: 0x01 ACKed and held; 0x02 NACKed; ovf=1; rx_data stays 0x01 until rx_ready=1.
- MAX_BYTES=2, write 0x78 then 0x10, 0x20, 0x30 with rx_ready=1.
  - Required: 0x10 and 0x20 ACKed; 0x30 NACKed; ovf stays 0.
- 1-clk glitches on SCL (FILTER_LEN=3) and a repeated START after 4 bits of a data byte, then 0x78, 0xC3.
  - Required: no spurious bits; the partial byte is dropped; 0xC3 is delivered with rx_first=1.
- Assert rst while sda_o=0 during an ACK.
  - Required: sda_o=1 and all outputs at their reset values on the next clk.
